// File: rtl/seg_pkg.sv
// Shared types and widths for the binary-to-BCD display loader.
package seg_pkg;
    localparam int BCD_W      = 4;
    localparam int NUM_DIGITS = 3;
    localparam int BIN_W      = 8;
    localparam int SR_W       = BCD_W*NUM_DIGITS + BIN_W;

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

    // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
    function automatic logic [BCD_W*NUM_DIGITS-1:0] dabble_adj(
        input logic [BCD_W*NUM_DIGITS-1:0] bcd);
        logic [BCD_W*NUM_DIGITS-1:0] r;
        r = bcd;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (bcd[i*BCD_W +: BCD_W] >= 4'd5)
                r[i*BCD_W +: BCD_W] = bcd[i*BCD_W +: BCD_W] + 4'd3;
        return r;
    endfunction
endpackage

// File: rtl/seg_bcd_loader_if.sv
// Valid/ready input handshake carrying the binary value to display.
interface seg_bcd_loader_if;
    import seg_pkg::*;
    logic             in_valid;
    logic [BIN_W-1:0] in_data;
    logic             in_ready;

    modport master (output in_valid, output in_data, input  in_ready);
    modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/seg_tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clocks.
module seg_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           cnt <= '0;
        else if (cnt == LAST) cnt <= '0;
        else                  cnt <= cnt + 1'b1;
    end

    assign tick = (cnt == LAST);
endmodule

// File: rtl/seg_bcd_loader.sv
// 8-bit binary to 3-digit BCD loader (serial double-dabble) with scan-tick prescaler.
module seg_bcd_loader
    import seg_pkg::*;
#(
    parameter int TICK_DIV = 50000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    seg_bcd_loader_if.slave  in_if,
    output logic [BCD_W-1:0] dig2,
    output logic [BCD_W-1:0] dig1,
    output logic [BCD_W-1:0] dig0,
    output logic             blank2,
    output logic             blank1,
    output logic             bcd_valid,
    output logic             scan_tick
);
    state_e          state;
    logic [SR_W-1:0] sr;
    logic [SR_W-1:0] sr_nxt;
    logic [2:0]      iter;

    assign sr_nxt = {dabble_adj(sr[SR_W-1:BIN_W]), sr[BIN_W-1:0]} << 1;

    // Digits are only written on the final iteration so partial sums never leak out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sr        <= '0;
            iter      <= '0;
            dig2      <= '0;
            dig1      <= '0;
            dig0      <= '0;
            bcd_valid <= 1'b0;
        end else begin
            bcd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_if.in_valid) begin
                        sr    <= {{(SR_W-BIN_W){1'b0}}, in_if.in_data};
                        iter  <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr   <= sr_nxt;
                    iter <= iter + 3'd1;
                    if (iter == 3'd7) begin
                        dig0      <= sr_nxt[BIN_W           +: BCD_W];
                        dig1      <= sr_nxt[BIN_W + BCD_W   +: BCD_W];
                        dig2      <= sr_nxt[BIN_W + 2*BCD_W +: BCD_W];
                        bcd_valid <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_if.in_ready = (state == IDLE);

    assign blank2 = BLANK_LZ && (dig2 == '0);
    assign blank1 = BLANK_LZ && (dig2 == '0) && (dig1 == '0);

    seg_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (scan_tick)
    );
endmodule

// File: tb/tb_seg_bcd_loader.sv
// Scoreboard bench: accepted values are queued, a monitor checks digits/flags/timing every cycle.
module tb_seg_bcd_loader;
    localparam int TD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg_bcd_loader_if bus();
    seg_bcd_loader_if bus_nb();
    assign bus_nb.in_valid = bus.in_valid;
    assign bus_nb.in_data  = bus.in_data;

    logic [3:0] d2, d1, d0, n2, n1, n0;
    logic b2, b1, bv, tk, nb2, nb1, nbv, ntk;

    seg_bcd_loader #(.TICK_DIV(TD), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_if(bus),
        .dig2(d2), .dig1(d1), .dig0(d0), .blank2(b2), .blank1(b1),
        .bcd_valid(bv), .scan_tick(tk));

    seg_bcd_loader #(.TICK_DIV(TD), .BLANK_LZ(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .in_if(bus_nb),
        .dig2(n2), .dig1(n1), .dig0(n0), .blank2(nb2), .blank1(nb1),
        .bcd_valid(nbv), .scan_tick(ntk));

    typedef struct { int val; int acc; } exp_t;
    exp_t q[$];

    int cyc = 0, rel = 0, busy_until = 0, exp_val = 0;
    int errs = 0, checks = 0;

    task automatic chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            errs++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Producer side of the scoreboard: record every transfer as it happens.
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) rel = 0;
        else        rel++;
        if (rst_n && bus.in_valid && bus.in_ready) begin
            q.push_back('{val: int'(bus.in_data), acc: cyc});
            busy_until = cyc + 8;
        end
    end

    // Monitor: reference is plain decimal arithmetic on the last completed value.
    always @(negedge clk) begin
        int exp_bv, exp_rdy, exp_tk;
        exp_bv = (q.size() > 0 && q[0].acc + 8 == cyc) ? 1 : 0;
        if (exp_bv != 0) begin
            exp_val = q[0].val;
            void'(q.pop_front());
        end
        exp_rdy = (!rst_n || cyc >= busy_until) ? 1 : 0;
        exp_tk  = (rst_n && rel % TD == TD - 1) ? 1 : 0;

        chk("bcd_valid", int'(bv), exp_bv);
        chk("dig2", int'(d2), exp_val / 100);
        chk("dig1", int'(d1), (exp_val / 10) % 10);
        chk("dig0", int'(d0), exp_val % 10);
        chk("bcd_legal", int'(d2 <= 9 && d1 <= 9 && d0 <= 9), 1);
        chk("blank2", int'(b2), int'(exp_val < 100));
        chk("blank1", int'(b1), int'(exp_val < 10));
        chk("in_ready", int'(bus.in_ready), exp_rdy);
        chk("scan_tick", int'(tk), exp_tk);

        chk("nb_bcd_valid", int'(nbv), exp_bv);
        chk("nb_digits", int'({n2, n1, n0}),
            int'({4'(exp_val / 100), 4'((exp_val / 10) % 10), 4'(exp_val % 10)}));
        chk("nb_blank2", int'(nb2), 0);
        chk("nb_blank1", int'(nb1), 0);
        chk("nb_in_ready", int'(bus_nb.in_ready), exp_rdy);
    end

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(int n);
        rst_n = 1'b0;
        q.delete();
        busy_until = 0;
        exp_val = 0;
        idle(n);
        rst_n = 1'b1;
    endtask

    // Offer v until accepted; with hold=1 in_valid stays high afterwards.
    task automatic send(int v, bit hold);
        int t;
        t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'(v);
        while (!bus.in_ready) begin
            idle(1);
            t++;
            if (t > 20) begin
                chk("accept_timeout", int'(bus.in_ready), 1);
                bus.in_valid = 1'b0;
                return;
            end
        end
        idle(1);
        if (!hold) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        #1;
        do_reset(3);
        idle(2);

        send(255, 1'b0); idle(12);
        send(7, 1'b0);   idle(12);

        send(100, 1'b1); send(42, 1'b1); send(9, 1'b0);
        idle(12);

        send(200, 1'b0);
        idle(3);
        do_reset(2);
        idle(3);

        for (int v = 0; v < 256; v++) begin
            send(v, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
                idle($urandom_range(1, 3));
            end
        end
        bus.in_valid = 1'b0;
        idle(12);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/seg_bcd_loader.md
SEG_BCD_LOADER -- requirements
Module: seg_bcd_loader

Interface
REQ-001 The block SHALL expose parameter TICK_DIV, default 50000, scan-tick period in clk cycles (1 kHz at 50 MHz), legal range 2..2^20.
REQ-002 The block SHALL expose parameter BLANK_LZ, default 1, meaning 1 enables leading-zero blank flags and 0 forces them low.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset, as listed in REQ-004 and REQ-005.
REQ-004 clk  input  1  sole clock, rising-edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  producer offers in_data.
REQ-007 in_data  input  8  unsigned binary value to display, 0..255.
REQ-008 in_ready  output  1  block can accept a value this cycle.
REQ-009 dig2, dig1, dig0  output  4 each  BCD hundreds, tens and units, registered.
REQ-010 blank2, blank1  output  1 each  leading-zero blank flags for the hundreds and tens digits.
REQ-011 bcd_valid  output  1  one-cycle pulse marking that new digits have been loaded.
REQ-012 scan_tick  output  1  one-cycle strobe that paces the downstream digit multiplexer.

Function
REQ-013 The FSM SHALL have states IDLE and SHIFT only.
REQ-014 in_ready SHALL be 1 exactly when the state is IDLE.
REQ-015 A transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; in_data is captured into an internal shift register and the state goes to SHIFT.
REQ-016 While in SHIFT, in_valid SHALL be ignored and in_data SHALL NOT be sampled.
REQ-017 Each SHIFT cycle SHALL perform one double-dabble iteration: add 3 to every BCD nibble >= 5, then shift the 20-bit {BCD,binary} register left by 1.
REQ-018 SHIFT SHALL last exactly 8 cycles, counted by a 3-bit iteration counter that wraps 7->0 on the last iteration.
REQ-019 On the 8th SHIFT edge, the block SHALL load dig2/dig1/dig0 with the final result, pulse bcd_valid for exactly one cycle, and return to IDLE.
REQ-020 Latency SHALL be 8 edges from the acceptance edge to the digit update, and 9 cycles from acceptance to the next possible acceptance.
REQ-021 If in_valid=1 in the same cycle that bcd_valid=1, the new value SHALL be accepted on that edge, because in_ready is already 1 in that cycle.
REQ-022 dig2/dig1/dig0 SHALL hold their previous values throughout a conversion; a partial result SHALL never be visible on them.
REQ-023 With BLANK_LZ=1, blank2 SHALL equal (dig2==0) and blank1 SHALL equal (dig2==0 && dig1==0), both derived from the registered digits.
REQ-024 The units digit SHALL never be blanked.
REQ-025 With BLANK_LZ=0, blank2 and blank1 SHALL both be 0.
REQ-026 The scan counter SHALL count 0..TICK_DIV-1 and wrap to 0, running freely and independently of the FSM.
REQ-027 scan_tick SHALL be 1 only in the cycle where the scan counter equals TICK_DIV-1.
REQ-028 Every output digit SHALL always hold a legal BCD value in 0..9.

Reset
REQ-029 Asserting rst_n=0 SHALL immediately force: state IDLE, in_ready=1 after release, dig2/dig1/dig0=0, bcd_valid=0, scan counter=0, scan_tick=0, iteration counter=0.
REQ-030 After reset, with BLANK_LZ=1, blank2=1 and blank1=1.
REQ-031 Reset asserted mid-conversion SHALL abort the conversion with no bcd_valid pulse and no digit update.
REQ-032 The first scan_tick after reset release SHALL occur TICK_DIV cycles after the first rising edge with rst_n=1.

Structure
REQ-033 Package seg_pkg SHALL hold the FSM state type (IDLE, SHIFT), BCD_W=4, NUM_DIGITS=3 and BIN_W=8.
REQ-034 The scan prescaler SHALL be a sub-module seg_tick_gen, parameterised by TICK_DIV, with ports clk, rst_n and tick.
REQ-035 The conversion datapath and FSM SHALL remain in seg_bcd_loader.

Verification
REQ-036 Scenario: in_data=255, single transfer -> 8 edges later dig2/dig1/dig0=2/5/5, bcd_valid pulses once, blank2=0, blank1=0.
REQ-037 Scenario: in_data=7 with BLANK_LZ=1 -> digits 0/0/7, blank2=1, blank1=1; repeat with BLANK_LZ=0 -> both blank flags 0.
REQ-038 Scenario: in_valid held high continuously with data 100, 42, 9 -> accepted every 9 cycles, digits in sequence 1/0/0, 0/4/2, 0/0/9, with no intermediate digit values visible.
REQ-039 Scenario: rst_n pulsed low 4 cycles after acceptance of 200 -> no bcd_valid, digits 0/0/0, in_ready=1 after release.
REQ-040 Scenario: TICK_DIV=4, 20 cycles after reset release -> scan_tick high on cycles 4, 8, 12, 16, 20 only, and unaffected by concurrent conversions.
REQ-041 Scenario: exhaustive sweep of in_data over 0..255 -> every result equals the decimal expansion and every digit is <= 9.
